uart_count_shift: RTL and testbench



---
 rtl/uart_count_shift.sv | 95 +++++++++
 tb/tb_uart_count_shift.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_count_shift.sv
// ---------------------------------------------------------------------------
// uart_count_shift
//
// Register datapath for the UART block. It holds one up-counter and one
// serial-in/parallel-out shift register. Each has its own enable, and they
// share a clock and a reset. The UART controller sequences the block only
// through the enables and the reset. The block has no state machine of its
// own.
//
// Parameters
//   D_WIDTH : counter width in bits (1..32)
//   WIDTH   : shift-register width in bits (1..32)
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset. Clears the counter and
//                  presets the shift register to all ones (idle line).
//   en           : counter increment enable
//   count        : registered counter value
//   count_max    : high when count == 2^D_WIDTH-1 (decode of count)
//   shift_en     : shift enable
//   serial_in    : raw rx line, not synchronized here
//   parallel_out : registered shift-register contents
//   all_zero     : high when parallel_out is all zeros (start-bit detect)
//
// Build option
//   UART_COUNT_SAT_EN : when defined, the counter saturates at
//                       2^D_WIDTH-1 instead of wrapping to 0.
// ---------------------------------------------------------------------------
module uart_count_shift #(
    parameter int D_WIDTH = 16,
    parameter int WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [D_WIDTH-1:0] count,
    output logic               count_max,
    input  logic               shift_en,
    input  logic               serial_in,
    output logic [WIDTH-1:0]   parallel_out,
    output logic               all_zero
);

    localparam logic [D_WIDTH-1:0] COUNT_TOP = {D_WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   SR_IDLE   = {WIDTH{1'b1}};

    // Next counter value for an enabled edge. Terminal-count behaviour is
    // chosen at build time.
    function automatic logic [D_WIDTH-1:0] next_count(input logic [D_WIDTH-1:0] cur);
`ifdef UART_COUNT_SAT_EN
        // Hold at the top so a missed terminal compare cannot run away.
        if (cur == COUNT_TOP)
            return cur;
        return cur + D_WIDTH'(1);
`else
        return cur + D_WIDTH'(1);
`endif
    endfunction

    // Right shift with the new bit entering at the MSB. With LSB-first
    // framing, the first received bit ends up in bit 0 after WIDTH shifts.
    // A one-bit register simply loads the incoming bit.
    logic [WIDTH-1:0] shift_next;

    generate
        if (WIDTH == 1) begin : g_sr_single
            assign shift_next = serial_in;
        end else begin : g_sr_multi
            assign shift_next = {serial_in, parallel_out[WIDTH-1:1]};
        end
    endgenerate

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= next_count(count);
    end

    // Shift register. The reset value is the idle line, so a freshly reset
    // window never reads as a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parallel_out <= SR_IDLE;
        else if (shift_en)
            parallel_out <= shift_next;
    end

    // Pure decodes of registered state.
    assign count_max = (count == COUNT_TOP);
    assign all_zero  = (parallel_out == '0);

endmodule

// File: tb/tb_uart_count_shift.sv
module tb_uart_count_shift;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en = 1'b0;
    logic shift_en = 1'b0;
    logic serial_in = 1'b1;

    // Instance A: 16-bit counter, 8-bit shift register
    logic [15:0] count_a;
    logic        count_max_a;
    logic [7:0]  po_a;
    logic        az_a;
    // Instance B: 4-bit counter, 4-bit shift register
    logic [3:0]  count_b;
    logic        count_max_b;
    logic [3:0]  po_b;
    logic        az_b;

    uart_count_shift #(.D_WIDTH(16), .WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .count(count_a), .count_max(count_max_a),
        .shift_en(shift_en), .serial_in(serial_in), .parallel_out(po_a), .all_zero(az_a)
    );

    uart_count_shift #(.D_WIDTH(4), .WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .count(count_b), .count_max(count_max_b),
        .shift_en(shift_en), .serial_in(serial_in), .parallel_out(po_b), .all_zero(az_b)
    );

    typedef struct {
        int cnt_a; int max_a; int po_a; int az_a;
        int cnt_b; int max_b; int po_b; int az_b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an integer count per instance and the full history of
    // received line bits. The register contents are the newest WIDTH bits,
    // with the newest bit at the MSB.
    int m_cnt_a;
    int m_cnt_b;
    bit hist[$];

    function automatic void model_reset();
        m_cnt_a = 0;
        m_cnt_b = 0;
        hist.delete();
        repeat (8) hist.push_back(1'b1);
    endfunction

    function automatic int next_cnt(int c, int w);
        int top;
        top = (1 << w) - 1;
`ifdef UART_COUNT_SAT_EN
        if (c == top) return c;
        return c + 1;
`else
        return (c + 1) % (top + 1);
`endif
    endfunction

    function automatic int sr_val(int w);
        int v;
        v = 0;
        for (int i = 0; i < w; i++)
            if (hist[hist.size() - 1 - i]) v += (1 << (w - 1 - i));
        return v;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.cnt_a = m_cnt_a;
        e.max_a = (m_cnt_a == 65535) ? 1 : 0;
        e.po_a  = sr_val(8);
        e.az_a  = (e.po_a == 0) ? 1 : 0;
        e.cnt_b = m_cnt_b;
        e.max_b = (m_cnt_b == 15) ? 1 : 0;
        e.po_b  = sr_val(4);
        e.az_b  = (e.po_b == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".count_a"},     32'(count_a),     32'(e.cnt_a));
        chk({tag, ".count_max_a"}, 32'(count_max_a), 32'(e.max_a));
        chk({tag, ".po_a"},        32'(po_a),        32'(e.po_a));
        chk({tag, ".all_zero_a"},  32'(az_a),        32'(e.az_a));
        chk({tag, ".count_b"},     32'(count_b),     32'(e.cnt_b));
        chk({tag, ".count_max_b"}, 32'(count_max_b), 32'(e.max_b));
        chk({tag, ".po_b"},        32'(po_b),        32'(e.po_b));
        chk({tag, ".all_zero_b"},  32'(az_b),        32'(e.az_b));
    endtask

    // Monitor: after every active edge, pop the expected response and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare_all("edge", e);
            end
        end
    end

    // One clock of stimulus: drive on the falling edge and queue the
    // expected state after the following rising edge.
    task automatic step(input bit e, input bit s, input bit d);
        @(negedge clk);
        en        = e;
        shift_en  = s;
        serial_in = d;
        if (e) begin
            m_cnt_a = next_cnt(m_cnt_a, 16);
            m_cnt_b = next_cnt(m_cnt_b, 4);
        end
        if (s) hist.push_back(d);
        sb.push_back(snapshot());
    endtask

    // Reset asserted between edges. It must act before the next edge and
    // dominate active enables across an edge.
    task automatic rst_pulse();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async", snapshot());
        en        = 1'b1;
        shift_en  = 1'b1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        compare_all("rst_hold", snapshot());
        @(negedge clk);
        rst       = 1'b0;
        en        = 1'b0;
        shift_en  = 1'b0;
        serial_in = 1'b1;
        sb.push_back(snapshot());
    endtask

    // Time bound for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a5_bits[8];

        model_reset();
        rst_pulse();

        // Enables low: everything holds
        repeat (5) step(0, 0, 1);

        // Count 10, then hold 3, then reset mid-count
        repeat (10) step(1, 0, 1);
        repeat (3) step(0, 0, 1);
        rst_pulse();

        // Long count: instance B reaches 15 and wraps (or saturates)
        repeat (20) step(1, 0, 1);
        rst_pulse();

        // 0xA5 received LSB first
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) step(0, 1, a5_bits[i]);
        step(0, 0, 0);
        rst_pulse();

        // Start detect on the 4-bit window, then one more 1 shifted in
        repeat (4) step(0, 1, 0);
        step(0, 1, 1);
        rst_pulse();

        // Both enables together, then a reset in the middle of it
        repeat (3) step(1, 1, 1);
        step(1, 1, 0);
        rst_pulse();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 40) == 0) rst_pulse();
        end

        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
